// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (port 0) and
// data load/store (port 1). Data has fixed priority, except that a fetch
// denied for STARVE_LIMIT consecutive IDLE cycles is granted next. Reads
// take one wait cycle, and a one-cycle response pulse returns the data.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   f_req_valid/ready, f_addr  fetch request handshake and byte address
//   f_resp_valid, f_rdata      fetch response pulse and read data
//   d_req_valid/ready, d_addr, d_wdata, d_we   data request (d_we=1 store)
//   d_resp_valid, d_rdata      load response pulse and read data
//   mem_addr, mem_data_in, mem_write, mem_data_out   memory instance side
//   busy                       high while a read is waiting for its data
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [DATA_WIDTH-1:0] f_addr,
    output logic                  f_resp_valid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_we,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);
    localparam logic       OWNER_F = 1'b0;
    localparam logic       OWNER_D = 1'b1;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  owner_r;
    logic                  owner_nxt_s;
    logic [DATA_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] addr_nxt_s;
    logic [7:0]            starve_cnt_r;
    logic [7:0]            starve_nxt_s;
    logic                  grant_f_s;
    logic                  grant_d_s;
    logic                  f_resp_r;
    logic                  d_resp_r;
    logic [DATA_WIDTH-1:0] f_rdata_r;
    logic [DATA_WIDTH-1:0] d_rdata_r;

    // Arbitration: starving fetch first, then data, then fetch; only in IDLE.
    always_comb begin
        grant_f_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if ((starve_cnt_r >= LIMIT_C) && f_req_valid) begin
                grant_f_s = 1'b1;
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
            end else if (f_req_valid) begin
                grant_f_s = 1'b1;
            end else begin
                grant_f_s = 1'b0;
            end
        end else begin
            grant_f_s = 1'b0;
        end
    end

    // Next-state, memory-side steering and starvation counter update.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        addr_nxt_s   = addr_r;
        starve_nxt_s = starve_cnt_r;
        f_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        mem_addr     = {DATA_WIDTH{1'b0}};
        mem_data_in  = {DATA_WIDTH{1'b0}};
        mem_write    = 1'b0;
        case (state_r)
            IDLE: begin
                f_req_ready = grant_f_s;
                d_req_ready = grant_d_s;
                if (grant_d_s) begin
                    mem_addr    = d_addr;
                    mem_data_in = d_wdata;
                    mem_write   = d_we;
                    // Stores complete at this edge; only loads wait.
                    if (!d_we) begin
                        state_nxt_s = RD_WAIT;
                        owner_nxt_s = OWNER_D;
                        addr_nxt_s  = d_addr;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (grant_f_s) begin
                    mem_addr    = f_addr;
                    state_nxt_s = RD_WAIT;
                    owner_nxt_s = OWNER_F;
                    addr_nxt_s  = f_addr;
                end else begin
                    state_nxt_s = IDLE;
                end
                if (grant_f_s) begin
                    starve_nxt_s = 8'd0;
                end else if (f_req_valid && (starve_cnt_r != 8'hFF)) begin
                    starve_nxt_s = starve_cnt_r + 8'd1;
                end else begin
                    starve_nxt_s = starve_cnt_r;
                end
            end
            RD_WAIT: begin
                // Hold the address so the memory keeps presenting the word.
                mem_addr    = addr_r;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, ownership, held address and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_F;
            addr_r       <= {DATA_WIDTH{1'b0}};
            starve_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            addr_r       <= addr_nxt_s;
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Response capture: memory data is valid during RD_WAIT, so it is
    // registered at the end of that cycle and pulsed for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_resp_r  <= 1'b0;
            d_resp_r  <= 1'b0;
            f_rdata_r <= {DATA_WIDTH{1'b0}};
            d_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            f_resp_r <= (state_r == RD_WAIT) && (owner_r == OWNER_F);
            d_resp_r <= (state_r == RD_WAIT) && (owner_r == OWNER_D);
            if ((state_r == RD_WAIT) && (owner_r == OWNER_F)) begin
                f_rdata_r <= mem_data_out;
            end
            if ((state_r == RD_WAIT) && (owner_r == OWNER_D)) begin
                d_rdata_r <= mem_data_out;
            end
        end
    end

    assign f_resp_valid = f_resp_r;
    assign d_resp_valid = d_resp_r;
    assign f_rdata      = f_rdata_r;
    assign d_rdata      = d_rdata_r;
    assign busy         = (state_r == RD_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small behavioural memory that
// returns read data one cycle after the address, as the real instance does.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid, f_req_ready, f_resp_valid;
    logic [31:0] f_addr, f_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_write, busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_resp_valid(f_resp_valid), .f_rdata(f_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_we(d_we), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory, 64 words, preloaded on the first edge.
    logic [31:0] mem [0:63];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[0]     <= 32'h00000013;
            mem[4]     <= 32'h00500093;
            mem[8]     <= 32'hA5A5A5A5;
            mem[32]    <= 32'h12345678;
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_data_in;
        end
        mem_data_out <= mem[mem_addr[7:2]];
    end

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic        dwe;
        logic        fr;
        logic        dr;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic        fresp;
        logic        dresp;
        logic [31:0] frd;
        logic [31:0] drd;
        logic        bsy;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic dv,
                                input logic [31:0] da, input logic [31:0] dw, input logic dwe,
                                input logic fr, input logic dr, input logic mw,
                                input logic [31:0] ma, input logic [31:0] md,
                                input logic fresp, input logic dresp,
                                input logic [31:0] frd, input logic [31:0] drd, input logic bsy);
        vec_t v;
        v.fv = fv; v.fa = fa; v.dv = dv; v.da = da; v.dw = dw; v.dwe = dwe;
        v.fr = fr; v.dr = dr; v.mw = mw; v.ma = ma; v.md = md;
        v.fresp = fresp; v.dresp = dresp; v.frd = frd; v.drd = drd; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fa, input logic dv,
                         input logic [31:0] da, input logic [31:0] dw, input logic dwe);
        f_req_valid = fv; f_addr = fa;
        d_req_valid = dv; d_addr = da; d_wdata = dw; d_we = dwe;
    endtask

    // Advance one cycle: inputs change #1 after the rising edge.
    task automatic step(input logic fv, input logic [31:0] fa, input logic dv,
                        input logic [31:0] da, input logic [31:0] dw, input logic dwe);
        @(posedge clk);
        #1;
        drive(fv, fa, dv, da, dw, dwe);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_f_ready"}, 32'(f_req_ready), 32'd0);
        chk({tag, "_d_ready"}, 32'(d_req_ready), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_f_resp"}, 32'(f_resp_valid), 32'd0);
        chk({tag, "_d_resp"}, 32'(d_resp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_starve_cnt"}, 32'(dut.starve_cnt_r), 32'd0);
    endtask

    initial begin
        // Store, load, both-valid, and contention/starvation sequences.
        vecs[0]  = mk(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0,  1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        vecs[1]  = mk(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        vecs[2]  = mk(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0,  1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00500093, 32'h0, 1'b0);
        vecs[3]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h0, 1'b1);
        vecs[4]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00500093, 32'h0, 1'b0);
        vecs[5]  = mk(1'b0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00500093, 32'h0, 1'b0);
        vecs[6]  = mk(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 1'b0,  1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h0, 1'b0);
        vecs[7]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h0, 1'b1);
        vecs[8]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00500093, 32'hDEADBEEF, 1'b0);
        vecs[9]  = mk(1'b1, 32'h0, 1'b1, 32'h80, 32'h0, 1'b0,  1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hDEADBEEF, 1'b0);
        vecs[10] = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hDEADBEEF, 1'b1);
        vecs[11] = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00500093, 32'h12345678, 1'b0);
        vecs[12] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h12345678, 1'b1);
        vecs[13] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00000013, 32'h12345678, 1'b0);
        for (int k = 14; k < 18; k++) begin
            vecs[k] = mk(1'b1, 32'h20, 1'b1, 32'h48, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h48, 32'hCAFE0001, 1'b0, 1'b0, 32'h00000013, 32'h12345678, 1'b0);
        end
        vecs[18] = mk(1'b1, 32'h20, 1'b1, 32'h48, 32'hCAFE0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h00000013, 32'h12345678, 1'b0);
        vecs[19] = mk(1'b0, 32'h0, 1'b1, 32'h48, 32'hCAFE0001, 1'b1,  1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h00000013, 32'h12345678, 1'b1);
        vecs[20] = mk(1'b0, 32'h0, 1'b1, 32'h48, 32'hCAFE0001, 1'b1,  1'b0, 1'b1, 1'b1, 32'h48, 32'hCAFE0001, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678, 1'b0);
        vecs[21] = mk(1'b1, 32'h20, 1'b1, 32'h48, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h48, 32'hCAFE0001, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678, 1'b0);
        vecs[22] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678, 1'b0);

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        check_idle("rst");
        rst = 1'b0;

        // Idle: no requests for five cycles.
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
            check_idle($sformatf("idle%0d", c));
        end

        // Table-driven sequences, one vector per cycle.
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].fv, vecs[i].fa, vecs[i].dv, vecs[i].da, vecs[i].dw, vecs[i].dwe);
            @(negedge clk);
            chk($sformatf("v%0d_f_ready", i), 32'(f_req_ready), 32'(vecs[i].fr));
            chk($sformatf("v%0d_d_ready", i), 32'(d_req_ready), 32'(vecs[i].dr));
            chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ma);
            chk($sformatf("v%0d_mem_data_in", i), mem_data_in, vecs[i].md);
            chk($sformatf("v%0d_f_resp", i), 32'(f_resp_valid), 32'(vecs[i].fresp));
            chk($sformatf("v%0d_d_resp", i), 32'(d_resp_valid), 32'(vecs[i].dresp));
            chk($sformatf("v%0d_f_rdata", i), f_rdata, vecs[i].frd);
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].drd);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
        end

        // Reset during RD_WAIT: the starve counter is 1 after the last vector.
        step(1'b0, 32'h0, 1'b1, 32'h80, 32'h0, 1'b0);
        @(negedge clk);
        chk("mid_load_grant", 32'(d_req_ready), 32'd1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy_in_rst", 32'(busy), 32'd0);
        chk("mid_f_rdata", f_rdata, 32'd0);
        chk("mid_d_rdata", d_rdata, 32'd0);
        check_idle("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("post_rst%0d", c));
            chk($sformatf("post_rst%0d_d_rdata", c), d_rdata, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data memory between two requesters: port 0 is instruction fetch and port 1 is data load/store.
- Sits between the core control/sequencer and the memory instance, replacing the separate instruction and data memory paths.
- Data requests have fixed priority over fetch, bounded by a starvation counter so fetch always makes progress.
- Owns memory read latency tracking and returns read data with a response pulse.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- STARVE_LIMIT, 4, number of consecutive cycles fetch may be denied before it gets priority; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- f_req_valid  input  1  fetch request valid.
- f_req_ready  output  1  fetch request accepted this cycle.
- f_addr  input  DATA_WIDTH  fetch byte address.
- f_resp_valid  output  1  one-cycle pulse; f_rdata valid.
- f_rdata  output  DATA_WIDTH  fetch read data.
- d_req_valid  input  1  data request valid.
- d_req_ready  output  1  data request accepted this cycle.
- d_addr  input  DATA_WIDTH  data byte address.
- d_wdata  input  DATA_WIDTH  store data.
- d_we  input  1  1 = store, 0 = load.
- d_resp_valid  output  1  one-cycle pulse for load data; stores get no response.
- d_rdata  output  DATA_WIDTH  load read data.
- mem_addr  output  DATA_WIDTH  memory address.
- mem_data_in  output  DATA_WIDTH  memory write data.
- mem_write  output  1  memory write strobe.
- mem_data_out  input  DATA_WIDTH  memory read data, valid the cycle after the address is presented.
- busy  output  1  high in RD_WAIT.

Behaviour:
- Reset state (asynchronous on rst high):
  - State is IDLE; starve_cnt = 0.
  - All resp_valid = 0; f_rdata = d_rdata = 0.
  - Any in-flight read is dropped and produces no response after reset releases.
- States: IDLE, RD_WAIT.
- IDLE arbitration (combinational, same cycle):
  - If starve_cnt >= STARVE_LIMIT and f_req_valid: grant fetch.
  - Else if d_req_valid: grant data.
  - Else if f_req_valid: grant fetch.
  - Else: no grant.
- Grant effects:
  - Granted port's req_ready = 1; the other port's = 0.
  - mem_addr / mem_data_in / mem_write are driven from the granted port.
  - mem_write = d_we only on a data grant; fetch never writes.
  - With no grant: mem_write = 0, mem_addr = 0, mem_data_in = 0.
- Transfers:
  - Store grant: the write commits at that clock edge. State stays IDLE, so back-to-back stores run one per cycle.
  - Read grant (fetch, or load with d_we = 0): latch the requester id; next state RD_WAIT.
- RD_WAIT:
  - Both req_ready = 0 and mem_write = 0; mem_addr holds the granted address.
  - At the clock edge, mem_data_out is captured into the owner's rdata and that owner's resp_valid is set for exactly the next cycle; return to IDLE.
- Read timing and throughput:
  - Read accepted at cycle T gives resp_valid at T+2.
  - A new request may be accepted in the same cycle resp_valid is high.
  - Sustained read throughput is 1 per 2 cycles.
- rdata holds its value until the next response to the same port.
- Starvation counter:
  - Increments (saturating at 255) in each IDLE cycle where f_req_valid = 1 and fetch is not granted.
  - Clears to 0 on any fetch grant.
  - Unchanged in RD_WAIT and when f_req_valid = 0.
- Requester rules:
  - A requester holds valid/addr/wdata/we stable until ready.
  - Request inputs changing in RD_WAIT are ignored.
- Simultaneous events:
  - Both valid with starve_cnt below limit: data wins.
  - Both valid at limit: fetch wins, counter clears, and data waits.
- Address is passed through unmodified; alignment is the requester's responsibility.

Test Plan:
- Fetch only: f_req_valid = 1, f_addr = 0x10, memory word 0x00500093 → f_req_ready = 1 at T, mem_write = 0, f_resp_valid = 1 at T+2 with f_rdata = 0x00500093, next accept at T+2.
- Store then load: d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF, then d_we = 0 same address → mem_write pulses at T, load accepted at T+1, d_resp_valid at T+3 with 0xDEADBEEF, no d_resp_valid for the store.
- Contention/starvation with STARVE_LIMIT = 4: d_we = 1 and d_req_valid held for 10 cycles, f_req_valid held → data granted cycles 0-3, fetch granted cycle 4, starve_cnt = 0 after, data resumes cycle 6.
- Both valid with starve_cnt = 0: load at 0x80 and fetch at 0x0 → data granted first, fetch granted at T+2 (overlapping d_resp_valid), f_resp_valid at T+4.
- Reset mid-read: assert rst during RD_WAIT → busy = 0 and all resp_valid = 0 immediately, no response after release, starve_cnt = 0.
- Idle: no valids for 5 cycles → mem_write = 0, both ready = 0, no responses, starve_cnt stays 0.
